sdr_scl_sequencer: RTL and testbench

Frame-level sequencer for the SDR SCL generator. It issues the START, counts SCL edges into 9-bit frames (8 data bits plus T/ACK), and switches the generator between open-drain for the header byte and push-pull for data bytes. It forwards stall requests from the datapath and parks SCL high at end of transfer. It sits between the SDR controller FSM and the SCL generator.

---
 rtl/sdr_scl_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_sdr_scl_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_scl_sequencer.sv
// Frame sequencer for the SDR SCL generator: START, 9-bit frames, OD/PP switching, stall, SCL park.
// Optional stall watchdog is built when SDR_SCL_SEQ_STALL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module sdr_scl_sequencer #(
    parameter int BYTE_CNT_W    = 4,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                  i_sdr_ctrl_clk,
    input  logic                  i_sdr_ctrl_rst_n,
    input  logic                  i_seq_start,
    input  logic [BYTE_CNT_W-1:0] i_seq_num_bytes,
    input  logic                  i_seq_od_header,
    input  logic                  i_seq_stall_req,
    input  logic                  i_scl_pos_edge,
    input  logic                  i_scl_neg_edge,
    output logic                  o_scl_gen_pp_od,
    output logic                  o_scl_gen_stall,
    output logic                  o_scl_idle,
    output logic                  o_timer_cas,
    output logic                  o_seq_busy,
    output logic [3:0]            o_seq_bit_cnt,
    output logic [BYTE_CNT_W-1:0] o_seq_byte_cnt,
    output logic                  o_seq_sample,
    output logic                  o_seq_done,
    output logic                  o_seq_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FRAME,
        S_SWITCH,
        S_STOP
    } state_t;

    localparam logic [BYTE_CNT_W-1:0] BYTE_ONE = 1;

    state_t                state_q, state_d;
    logic [BYTE_CNT_W-1:0] num_bytes_q, num_bytes_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  od_header_q, od_header_d;
    logic                  pp_od_q, pp_od_d;
    logic                  stall_q, stall_d;
    logic                  idle_q, idle_d;
    logic                  cas_q, cas_d;
    logic                  busy_q, busy_d;
    logic                  sample_q, sample_d;
    logic                  done_q, done_d;
    logic                  in_frame;

`ifdef SDR_SCL_SEQ_STALL_TIMEOUT_EN
    localparam int              SC_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [SC_W-1:0] SC_ONE = 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STALL_TIMEOUT);

    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            abort_q, abort_d;
`endif

    always_comb begin
        state_d     = state_q;
        num_bytes_d = num_bytes_q;
        byte_cnt_d  = byte_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        od_header_d = od_header_q;
        pp_od_d     = pp_od_q;
        idle_d      = idle_q;
        busy_d      = busy_q;
        cas_d       = 1'b0;
        sample_d    = 1'b0;
        done_d      = 1'b0;
        in_frame    = (state_q == S_FRAME) || (state_q == S_SWITCH);
        stall_d     = i_seq_stall_req && in_frame;

        case (state_q)
            S_IDLE: begin
                idle_d  = 1'b1;
                pp_od_d = 1'b0;
                if (i_seq_start && (i_seq_num_bytes != '0)) begin
                    num_bytes_d = i_seq_num_bytes;
                    od_header_d = i_seq_od_header;
                    busy_d      = 1'b1;
                    cas_d       = 1'b1;
                    bit_cnt_d   = 4'd0;
                    byte_cnt_d  = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (i_scl_neg_edge) begin
                    idle_d  = 1'b0;
                    pp_od_d = !od_header_q;
                    state_d = S_FRAME;
                end
            end
            S_FRAME: begin
                if (i_scl_pos_edge) begin
                    if (bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        sample_d  = 1'b1;
                    end else if (byte_cnt_q == (num_bytes_q - BYTE_ONE)) begin
                        // Park SCL before the generator can issue another falling edge
                        bit_cnt_d = 4'd0;
                        idle_d    = 1'b1;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = byte_cnt_q + BYTE_ONE;
                        state_d    = S_SWITCH;
                    end
                end
            end
            S_SWITCH: begin
                // Mode changes only once SCL has gone low
                if (i_scl_neg_edge) begin
                    pp_od_d = 1'b1;
                    state_d = S_FRAME;
                end
            end
            S_STOP: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pp_od_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SDR_SCL_SEQ_STALL_TIMEOUT_EN
        abort_d     = 1'b0;
        stall_cnt_d = stall_q ? (stall_cnt_q + SC_ONE) : '0;
        if (stall_q && ((stall_cnt_q + SC_ONE) == SC_MAX)) begin
            abort_d     = 1'b1;
            stall_d     = 1'b0;
            stall_cnt_d = '0;
            idle_d      = 1'b1;
            busy_d      = 1'b0;
            pp_od_d     = 1'b0;
            sample_d    = 1'b0;
            state_d     = S_IDLE;
        end
`endif
    end

    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            state_q     <= S_IDLE;
            num_bytes_q <= '0;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            od_header_q <= 1'b0;
            pp_od_q     <= 1'b0;
            stall_q     <= 1'b0;
            idle_q      <= 1'b1;
            cas_q       <= 1'b0;
            busy_q      <= 1'b0;
            sample_q    <= 1'b0;
            done_q      <= 1'b0;
`ifdef SDR_SCL_SEQ_STALL_TIMEOUT_EN
            stall_cnt_q <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            num_bytes_q <= num_bytes_d;
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            od_header_q <= od_header_d;
            pp_od_q     <= pp_od_d;
            stall_q     <= stall_d;
            idle_q      <= idle_d;
            cas_q       <= cas_d;
            busy_q      <= busy_d;
            sample_q    <= sample_d;
            done_q      <= done_d;
`ifdef SDR_SCL_SEQ_STALL_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
            abort_q     <= abort_d;
`endif
        end
    end

    assign o_scl_gen_pp_od = pp_od_q;
    assign o_scl_gen_stall = stall_q;
    assign o_scl_idle      = idle_q;
    assign o_timer_cas     = cas_q;
    assign o_seq_busy      = busy_q;
    assign o_seq_bit_cnt   = bit_cnt_q;
    assign o_seq_byte_cnt  = byte_cnt_q;
    assign o_seq_sample    = sample_q;
    assign o_seq_done      = done_q;
`ifdef SDR_SCL_SEQ_STALL_TIMEOUT_EN
    assign o_seq_abort     = abort_q;
`else
    assign o_seq_abort     = 1'b0;
`endif

endmodule

// File: tb/tb_sdr_scl_sequencer.sv
// Bench for sdr_scl_sequencer: a randomized SCL generator model drives edges, and a frame-level
// reference (edge index -> bit/byte/sample/mode) checks the sequencer against it.
`timescale 1ns/1ps
module tb_sdr_scl_sequencer;

    logic       clk;
    logic       rst_n;
    logic       i_seq_start;
    logic [3:0] i_seq_num_bytes;
    logic       i_seq_od_header;
    logic       i_seq_stall_req;
    logic       i_scl_pos_edge;
    logic       i_scl_neg_edge;
    logic       o_scl_gen_pp_od;
    logic       o_scl_gen_stall;
    logic       o_scl_idle;
    logic       o_timer_cas;
    logic       o_seq_busy;
    logic [3:0] o_seq_bit_cnt;
    logic [3:0] o_seq_byte_cnt;
    logic       o_seq_sample;
    logic       o_seq_done;
    logic       o_seq_abort;

    sdr_scl_sequencer #(.BYTE_CNT_W(4), .STALL_TIMEOUT(16)) dut (
        .i_sdr_ctrl_clk   (clk),
        .i_sdr_ctrl_rst_n (rst_n),
        .i_seq_start      (i_seq_start),
        .i_seq_num_bytes  (i_seq_num_bytes),
        .i_seq_od_header  (i_seq_od_header),
        .i_seq_stall_req  (i_seq_stall_req),
        .i_scl_pos_edge   (i_scl_pos_edge),
        .i_scl_neg_edge   (i_scl_neg_edge),
        .o_scl_gen_pp_od  (o_scl_gen_pp_od),
        .o_scl_gen_stall  (o_scl_gen_stall),
        .o_scl_idle       (o_scl_idle),
        .o_timer_cas      (o_timer_cas),
        .o_seq_busy       (o_seq_busy),
        .o_seq_bit_cnt    (o_seq_bit_cnt),
        .o_seq_byte_cnt   (o_seq_byte_cnt),
        .o_seq_sample     (o_seq_sample),
        .o_seq_done       (o_seq_done),
        .o_seq_abort      (o_seq_abort)
    );

    int n_checks = 0;
    int n_err    = 0;

    // reference / environment state
    logic scl_m;
    int   hcnt, lcnt;
    bit   startp, prev_pos, prev_first, ack_pending, frame_m, frame_s, req_s;
    bit   model_active = 0;
    bit   chk_stall    = 1;
    int   k = 0;
    int   exp_n = 1;
    bit   exp_od = 0;
    int   n_cas = 0, n_pos = 0, n_sample = 0, n_done = 0, n_abort = 0;
    int   low_run = 0, max_low_run = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // SCL generator model plus per-edge frame reference
    initial begin : env
        bit          pos_n, neg_n, first_n;
        int          ph, by;
        bit          last;
        logic [31:0] e;
        scl_m = 1'b1; hcnt = 0; lcnt = 0; startp = 0; prev_pos = 0; prev_first = 0;
        ack_pending = 0; frame_m = 0;
        i_scl_pos_edge = 1'b0;
        i_scl_neg_edge = 1'b0;
        forever begin
            @(posedge clk);
            req_s   = i_seq_stall_req;
            frame_s = frame_m;
            @(negedge clk);
            pos_n = 0; neg_n = 0; first_n = 0;
            if (o_timer_cas)  n_cas++;
            if (o_seq_sample) n_sample++;
            if (o_seq_done)   n_done++;
            if (o_seq_abort) begin
                n_abort++;
                model_active = 0;
                frame_m = 0;
            end
            if (chk_stall && rst_n) check("stall_lag", o_scl_gen_stall, req_s && frame_s);
            if (!rst_n) begin
                frame_m = 0; ack_pending = 0; startp = 0;
            end
            if (prev_first && model_active) begin
                check("idle_cleared", o_scl_idle, 1'b0);
                check("pp_od_first", o_scl_gen_pp_od, !exp_od);
                frame_m = 1;
            end
            if (ack_pending) begin
                check("done_timing", o_seq_done, 1'b1);
                ack_pending = 0;
            end
            if (prev_pos && model_active) begin
                ph   = k % 9;
                by   = k / 9;
                last = (k == 9 * exp_n - 1);
                n_pos++;
                check("sample", o_seq_sample, ph < 8);
                if (!last) begin
                    check("bit_cnt", o_seq_bit_cnt, (ph == 8) ? 0 : ph + 1);
                    check("byte_cnt", o_seq_byte_cnt, (ph == 8) ? by + 1 : by);
                end else begin
                    check("byte_cnt_last", o_seq_byte_cnt, by);
                    check("idle_after_last", o_scl_idle, 1'b1);
                    frame_m = 0;
                    ack_pending = 1;
                end
                k++;
            end
            if (scl_m) begin
                if (o_timer_cas) begin
                    startp = 1;
                    hcnt = $urandom_range(2, 5);
                end else if (hcnt > 0) begin
                    hcnt--;
                end else if (startp || !o_scl_idle) begin
                    scl_m = 1'b0; neg_n = 1; first_n = startp; startp = 0;
                    lcnt = $urandom_range(2, 5);
                end
            end else begin
                if (lcnt > 0) begin
                    lcnt--;
                end else if (!o_scl_gen_stall) begin
                    if (model_active && k < 9 * exp_n) begin
                        e = (k < 9) ? {31'd0, ~exp_od} : 32'd1;
                        check("pp_od", o_scl_gen_pp_od, e);
                    end
                    scl_m = 1'b1; pos_n = 1;
                    hcnt = $urandom_range(2, 5);
                end
            end
            if (!scl_m) low_run++; else low_run = 0;
            if (low_run > max_low_run) max_low_run = low_run;
            i_scl_pos_edge = pos_n;
            i_scl_neg_edge = neg_n;
            prev_pos   = pos_n;
            prev_first = first_n;
        end
    end

    task automatic begin_xfer(input int n, input bit od);
        n_cas = 0; n_pos = 0; n_sample = 0; n_done = 0; n_abort = 0; max_low_run = 0;
        k = 0; exp_n = n; exp_od = od; model_active = 1;
        @(negedge clk);
        i_seq_start = 1'b1; i_seq_num_bytes = 4'(n); i_seq_od_header = od;
        @(negedge clk);
        i_seq_start = 1'b0; i_seq_num_bytes = 4'($urandom); i_seq_od_header = 1'($urandom);
        check("busy_set", o_seq_busy, 1'b1);
        check("cas_pulse", o_timer_cas, 1'b1);
        @(negedge clk);
        check("cas_clear", o_timer_cas, 1'b0);
    endtask

    task automatic wait_k(input int target);
        int cyc = 0;
        while (k < target && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_edges", k >= target, 1'b1);
    endtask

    task automatic run_xfer(input int n, input bit od, input bit mid_start, input bit do_stall,
                            input bit rnd_stall);
        int cyc = 0;
        begin_xfer(n, od);
        if (mid_start) begin
            wait_k(5);
            @(negedge clk);
            i_seq_start = 1'b1; i_seq_num_bytes = 4'd7;
            @(negedge clk);
            i_seq_start = 1'b0;
        end
        if (do_stall) begin
            wait_k(13);
            i_seq_stall_req = 1'b1;
            repeat (40) begin
                @(negedge clk);
                check("bit_frozen", o_seq_bit_cnt, 4'd4);
            end
            i_seq_stall_req = 1'b0;
        end
        while (n_done == 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (rnd_stall) i_seq_stall_req = ($urandom_range(0, 5) == 0);
        end
        i_seq_stall_req = 1'b0;
        check("done_seen", n_done > 0, 1'b1);
        @(negedge clk);
        check("cas_count", n_cas, 1);
        check("rise_count", n_pos, 9 * n);
        check("sample_count", n_sample, 8 * n);
        check("busy_clear", o_seq_busy, 1'b0);
        check("pp_od_idle", o_scl_gen_pp_od, 1'b0);
        if (do_stall) check("stall_low_run", max_low_run >= 34, 1'b1);
        repeat (20) @(negedge clk);
        check("scl_parked", scl_m, 1'b1);
        check("done_count", n_done, 1);
        check("abort_none", n_abort, 0);
    endtask

    initial begin : stim
        rst_n = 1'b0;
        i_seq_start = 1'b0; i_seq_num_bytes = 4'd5; i_seq_od_header = 1'b1; i_seq_stall_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_idle", o_scl_idle, 1'b1);
        check("rst_cas", o_timer_cas, 1'b0);
        check("rst_busy", o_seq_busy, 1'b0);
        check("rst_pp_od", o_scl_gen_pp_od, 1'b0);
        check("rst_stall", o_scl_gen_stall, 1'b0);
        check("rst_bit", o_seq_bit_cnt, 4'd0);
        check("rst_byte", o_seq_byte_cnt, 4'd0);
        check("rst_done", o_seq_done, 1'b0);
        check("rst_abort", o_seq_abort, 1'b0);
        i_seq_stall_req = 1'b0;
        i_seq_start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        i_seq_start = 1'b0;
        repeat (5) @(negedge clk);
        check("park_after_rst", scl_m, 1'b1);
        check("busy_after_rst", o_seq_busy, 1'b0);

        run_xfer(3, 1'b1, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        i_seq_start = 1'b1; i_seq_num_bytes = 4'd0;
        @(negedge clk);
        i_seq_start = 1'b0;
        check("zero_busy", o_seq_busy, 1'b0);
        check("zero_cas", o_timer_cas, 1'b0);
        repeat (10) @(negedge clk);
        check("zero_byte", o_seq_byte_cnt, 4'd2);
        check("zero_done", n_done, 1);
        check("zero_scl", scl_m, 1'b1);

        run_xfer(1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_xfer(3, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) run_xfer($urandom_range(1, 4), 1'($urandom), 1'b0, 1'b0, 1'b1);
        run_xfer(15, 1'($urandom), 1'b0, 1'b0, 1'b0);

        begin_xfer(5, 1'($urandom));
        wait_k(7);
        model_active = 0;
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_idle", o_scl_idle, 1'b1);
        check("mid_rst_busy", o_seq_busy, 1'b0);
        check("mid_rst_pp_od", o_scl_gen_pp_od, 1'b0);
        check("mid_rst_bit", o_seq_bit_cnt, 4'd0);
        check("mid_rst_byte", o_seq_byte_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_rst_park", scl_m, 1'b1);
        check("mid_rst_nodone", n_done, 0);

`ifdef SDR_SCL_SEQ_STALL_TIMEOUT_EN
        begin
            int cyc = 0;
            chk_stall = 0;
            begin_xfer(3, 1'b1);
            wait_k(13);
            i_seq_stall_req = 1'b1;
            while (!o_seq_abort && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("abort_latency", cyc, 17);
            check("abort_stall", o_scl_gen_stall, 1'b0);
            check("abort_idle", o_scl_idle, 1'b1);
            check("abort_busy", o_seq_busy, 1'b0);
            i_seq_stall_req = 1'b0;
            repeat (30) @(negedge clk);
            check("abort_nodone", n_done, 0);
            check("abort_count", n_abort, 1);
            check("abort_park", scl_m, 1'b1);
            chk_stall = 1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
